merge_arb_4i: RTL and testbench



---
 rtl/merge_arb_4i_if.sv | 38 +++
 rtl/merge_arb_4i.sv | 146 ++++++++++++++
 tb/tb_merge_arb_4i.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/merge_arb_4i_if.sv
// rtl/merge_arb_4i_if.sv - four-requester pixel merge bus between conv channels and the merge lane
interface merge_arb_4i_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in_1;
  logic                  valid_in_2;
  logic                  valid_in_3;
  logic                  valid_in_4;
  logic [DATA_WIDTH-1:0] pxl_in_1;
  logic [DATA_WIDTH-1:0] pxl_in_2;
  logic [DATA_WIDTH-1:0] pxl_in_3;
  logic [DATA_WIDTH-1:0] pxl_in_4;
  logic                  ready_out_1;
  logic                  ready_out_2;
  logic                  ready_out_3;
  logic                  ready_out_4;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_out;
  logic                  ready_in;
  logic [1:0]            grant;
  logic                  burst_done;

  modport slave (
    input  valid_in_1, valid_in_2, valid_in_3, valid_in_4,
    input  pxl_in_1, pxl_in_2, pxl_in_3, pxl_in_4,
    input  ready_in,
    output ready_out_1, ready_out_2, ready_out_3, ready_out_4,
    output pxl_out, valid_out, grant, burst_done
  );

  modport master (
    output valid_in_1, valid_in_2, valid_in_3, valid_in_4,
    output pxl_in_1, pxl_in_2, pxl_in_3, pxl_in_4,
    output ready_in,
    input  ready_out_1, ready_out_2, ready_out_3, ready_out_4,
    input  pxl_out, valid_out, grant, burst_done
  );
endinterface

// File: rtl/merge_arb_4i.sv
// rtl/merge_arb_4i.sv - four-input burst round-robin merge arbiter with registered output
// Optional stalled-burst release enabled by MERGE_ARB_TIMEOUT_EN (adds timeout_err).
module merge_arb_4i #(
  parameter int D          = 220,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic           clk,
  input  logic           reset,
  merge_arb_4i_if.slave  bus
`ifdef MERGE_ARB_TIMEOUT_EN
  ,
  output logic           timeout_err
`endif
);
  localparam int CW = $clog2(D + 1);

  typedef enum logic {S_IDLE, S_SERVE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_grant;
  logic [1:0]            r_last;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_pxl;
  logic                  r_valid;
  logic                  r_done;

  logic [3:0]            w_vld;
  logic [DATA_WIDTH-1:0] w_pxl [4];
  logic [1:0]            w_win;
  logic [1:0]            w_idx;
  logic                  w_win_ok;
  logic                  w_slot_free;
  logic                  w_serve_free;
  logic                  w_g_valid;
  logic                  w_xfer;
  logic                  w_last_beat;
  logic                  w_tmo;

  assign w_vld    = {bus.valid_in_4, bus.valid_in_3, bus.valid_in_2, bus.valid_in_1};
  assign w_pxl[0] = bus.pxl_in_1;
  assign w_pxl[1] = bus.pxl_in_2;
  assign w_pxl[2] = bus.pxl_in_3;
  assign w_pxl[3] = bus.pxl_in_4;

  assign w_slot_free  = !r_valid || bus.ready_in;
  assign w_serve_free = (r_state == S_SERVE) && w_slot_free;
  assign w_g_valid    = w_vld[r_grant];
  assign w_xfer       = w_serve_free && w_g_valid;
  assign w_last_beat  = (r_cnt == CW'(D - 1));

  assign bus.ready_out_1 = w_serve_free && (r_grant == 2'd0);
  assign bus.ready_out_2 = w_serve_free && (r_grant == 2'd1);
  assign bus.ready_out_3 = w_serve_free && (r_grant == 2'd2);
  assign bus.ready_out_4 = w_serve_free && (r_grant == 2'd3);
  assign bus.pxl_out     = r_pxl;
  assign bus.valid_out   = r_valid;
  assign bus.grant       = r_grant;
  assign bus.burst_done  = r_done;

  // Scan farthest-first so the index nearest to last+1 overwrites and wins.
  always_comb begin
    w_win    = 2'd0;
    w_win_ok = 1'b0;
    w_idx    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_last + 2'(k + 1);
      if (w_vld[w_idx]) begin
        w_win    = w_idx;
        w_win_ok = 1'b1;
      end
    end
  end

`ifdef MERGE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_idle;
  logic          r_tmo_err;

  assign w_tmo       = (r_state == S_SERVE) && !w_g_valid && (r_idle == TW'(TIMEOUT - 1));
  assign timeout_err = r_tmo_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle    <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_err <= w_tmo;
      if (r_state != S_SERVE || w_xfer || w_tmo) begin
        r_idle <= '0;
      end else if (!w_g_valid) begin
        r_idle <= r_idle + TW'(1);
      end
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_win_ok) w_state_nxt = S_SERVE;
      S_SERVE: if ((w_xfer && w_last_beat) || w_tmo) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // last resets to 3 so the first search after reset starts at input 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant <= 2'd0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
      r_pxl   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_xfer && w_last_beat;
      if (w_xfer) begin
        r_pxl   <= w_pxl[r_grant];
        r_valid <= 1'b1;
      end else if (bus.ready_in) begin
        r_valid <= 1'b0;
      end
      if (r_state == S_IDLE && w_win_ok) begin
        r_grant <= w_win;
        r_cnt   <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if ((w_xfer && w_last_beat) || w_tmo) begin
        r_last <= r_grant;
      end
    end
  end
endmodule

// File: tb/tb_merge_arb_4i.sv
// tb/tb_merge_arb_4i.sv - directed-vector bench for merge_arb_4i with D=4
module tb_merge_arb_4i;
  localparam int TMO = 8;
`ifdef MERGE_ARB_TIMEOUT_EN
  localparam int SIL = 6;
`else
  localparam int SIL = 10;
`endif

  logic clk;
  logic reset;
  logic timeout_err;

  merge_arb_4i_if #(.DATA_WIDTH(32)) bus ();

  merge_arb_4i #(.D(4), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus)
`ifdef MERGE_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

`ifndef MERGE_ARB_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int mem [4][32];
  int hd [4];
  int tl [4];
  bit en [4];

  int         t;
  logic       tr_vo  [64];
  logic [31:0] tr_px [64];
  logic [1:0] tr_g   [64];
  logic       tr_bd  [64];
  logic [3:0] tr_rdy [64];
  logic       tr_te  [64];

  int e1_vo [11] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  int e1_px [11] = '{0, 0, 1, 2, 3, 4, 0, 5, 6, 7, 8};

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rdy_vec();
    return {bus.ready_out_4, bus.ready_out_3, bus.ready_out_2, bus.ready_out_1};
  endfunction

  function automatic logic [3:0] vld_vec();
    return {bus.valid_in_4, bus.valid_in_3, bus.valid_in_2, bus.valid_in_1};
  endfunction

  task automatic drive();
    bus.valid_in_1 = en[0] && (hd[0] < tl[0]);
    bus.valid_in_2 = en[1] && (hd[1] < tl[1]);
    bus.valid_in_3 = en[2] && (hd[2] < tl[2]);
    bus.valid_in_4 = en[3] && (hd[3] < tl[3]);
    bus.pxl_in_1   = mem[0][hd[0]];
    bus.pxl_in_2   = mem[1][hd[1]];
    bus.pxl_in_3   = mem[2][hd[2]];
    bus.pxl_in_4   = mem[3][hd[3]];
  endtask

  task automatic load(input int i, input int base, input int n);
    for (int k = 0; k < n; k++) mem[i][k] = base + k;
    hd[i] = 0;
    tl[i] = n;
  endtask

  task automatic tick();
    logic [3:0] acc;
    acc = vld_vec() & rdy_vec();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) if (acc[i]) hd[i]++;
    drive();
    #1;
    t++;
    tr_vo[t]  = bus.valid_out;
    tr_px[t]  = bus.pxl_out;
    tr_g[t]   = bus.grant;
    tr_bd[t]  = bus.burst_done;
    tr_rdy[t] = rdy_vec();
    tr_te[t]  = timeout_err;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0;
      hd[i] = 0;
      tl[i] = 0;
      for (int k = 0; k < 32; k++) mem[i][k] = 0;
    end
    drive();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    t = 0;
  endtask

  initial begin
    int seq [32];
    int nseq;
    int bad;
    int base;

    reset = 1'b1;
    bus.ready_in = 1'b1;

    // single requester, back-to-back bursts
    do_reset();
    #1;
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_pxl_out", bus.pxl_out, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_burst_done", bus.burst_done, 0);
    check("rst_ready_out", rdy_vec(), 0);
    load(0, 1, 8);
    en[0] = 1'b1;
    drive();
    #1;
    repeat (11) tick();
    for (int k = 2; k <= 10; k++) begin
      check($sformatf("t1_vo_%0d", k), tr_vo[k], e1_vo[k]);
      if (e1_vo[k] != 0) check($sformatf("t1_px_%0d", k), tr_px[k], e1_px[k]);
      check($sformatf("t1_bd_%0d", k), tr_bd[k], (k == 5 || k == 10) ? 1 : 0);
      check($sformatf("t1_g_%0d", k), tr_g[k], 0);
    end
    check("t1_vo_end", tr_vo[11], 0);

    // all four requesting: rotation and one bubble per burst
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(i, 16 * i + 1, 8);
      en[i] = 1'b1;
    end
    drive();
    #1;
    repeat (21) tick();
    nseq = 0;
    bad  = 0;
    for (int k = 1; k <= 20; k++) begin
      if (tr_vo[k]) begin
        seq[nseq] = tr_px[k];
        nseq++;
      end
    end
    for (int k = 1; k <= 21; k++) begin
      if (tr_rdy[k] != 4'd0 && tr_rdy[k] != (4'd1 << tr_g[k])) bad++;
    end
    check("t2_pixel_count", nseq, 16);
    for (int j = 0; j < 16; j++) check($sformatf("t2_seq_%0d", j), seq[j], 16 * (j / 4) + (j % 4) + 1);
    check("t2_g_1", tr_g[1], 0);
    check("t2_g_6", tr_g[6], 1);
    check("t2_g_11", tr_g[11], 2);
    check("t2_g_16", tr_g[16], 3);
    check("t2_g_21", tr_g[21], 0);
    check("t2_bubble_6", tr_vo[6], 0);
    check("t2_bubble_11", tr_vo[11], 0);
    check("t2_bubble_16", tr_vo[16], 0);
    check("t2_ready_onehot_viol", bad, 0);

    // downstream backpressure on input 3
    do_reset();
    load(2, 101, 4);
    en[2] = 1'b1;
    drive();
    #1;
    repeat (3) tick();
    check("t3_px_before", tr_px[3], 102);
    bus.ready_in = 1'b0;
    #1;
    check("t3_rdy3_stall_now", rdy_vec(), 0);
    repeat (5) begin
      tick();
      check($sformatf("t3_px_hold_%0d", t), tr_px[t], 102);
      check($sformatf("t3_vo_hold_%0d", t), tr_vo[t], 1);
      check($sformatf("t3_rdy3_%0d", t), tr_rdy[t][2], 0);
    end
    bus.ready_in = 1'b1;
    #1;
    repeat (3) tick();
    check("t3_px3", tr_px[9], 103);
    check("t3_px4", tr_px[10], 104);
    check("t3_bd4", tr_bd[10], 1);
    check("t3_vo_after", tr_vo[11], 0);
    check("t3_consumed", hd[2], 4);

    // granted source stalls mid-burst, other source must wait
    do_reset();
    load(1, 201, 4);
    load(0, 1, 4);
    en[1] = 1'b1;
    drive();
    #1;
    repeat (3) tick();
    check("t4_g_start", tr_g[1], 1);
    check("t4_px2", tr_px[3], 202);
    en[1] = 1'b0;
    en[0] = 1'b1;
    drive();
    #1;
    repeat (SIL) begin
      tick();
      check($sformatf("t4_g_%0d", t), tr_g[t], 1);
      check($sformatf("t4_rdy1_%0d", t), tr_rdy[t][0], 0);
    end
    en[1] = 1'b1;
    drive();
    #1;
    base = t;
    repeat (4) tick();
    check("t4_px3", tr_px[base + 1], 203);
    check("t4_px4", tr_px[base + 2], 204);
    check("t4_bd", tr_bd[base + 2], 1);
    check("t4_bubble", tr_vo[base + 3], 0);
    check("t4_g_next", tr_g[base + 3], 0);
    check("t4_in1_first", tr_px[base + 4], 1);

    // asynchronous reset mid-burst
    do_reset();
    load(2, 301, 8);
    en[2] = 1'b1;
    drive();
    #1;
    repeat (3) tick();
    load(1, 401, 4);
    en[1] = 1'b1;
    drive();
    #1;
    check("t5_vo_pre", bus.valid_out, 1);
    check("t5_g_pre", bus.grant, 2);
    #2;
    reset = 1'b1;
    #1;
    check("t5_vo_async", bus.valid_out, 0);
    check("t5_rdy_async", rdy_vec(), 0);
    check("t5_g_async", bus.grant, 0);
    check("t5_px_async", bus.pxl_out, 0);
    @(negedge clk);
    reset = 1'b0;
    drive();
    #1;
    tick();
    check("t5_g_after", tr_g[t], 1);

`ifdef MERGE_ARB_TIMEOUT_EN
    // forced release of a silent requester
    do_reset();
    load(0, 601, 1);
    load(1, 701, 4);
    en[0] = 1'b1;
    en[1] = 1'b1;
    drive();
    #1;
    repeat (12) tick();
    bad = 0;
    for (int k = 1; k <= 11; k++) if (tr_bd[k]) bad++;
    check("t6_px1", tr_px[2], 601);
    check("t6_te_9", tr_te[9], 0);
    check("t6_te_10", tr_te[10], 1);
    check("t6_te_11", tr_te[11], 0);
    check("t6_g_11", tr_g[11], 1);
    check("t6_no_bd", bad, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
